// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : param_register_file
// Description : Parametrised multi-port register file. Register 0 is
//               hardwired to zero, same-cycle writes are bypassed to reads,
//               and a busy scoreboard tracks outstanding producers.
// Revision    : 1.0
// ============================================================================
module param_register_file #(
   parameter  int DATA_WIDTH      = 32,
   parameter  int NUM_REGS        = 16,
   parameter  int NUM_READ_PORTS  = 3,
   parameter  int NUM_WRITE_PORTS = 2,
   parameter  int REGISTERED_READ = 0,
   localparam int SEL_W           = $clog2(NUM_REGS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_READ_PORTS*SEL_W-1:0]      rd_sel_i,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_o,
   output logic [NUM_READ_PORTS-1:0]            rd_busy_o,
   input  logic [NUM_WRITE_PORTS-1:0]           wr_en_i,
   input  logic [NUM_WRITE_PORTS*SEL_W-1:0]     wr_sel_i,
   input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data_i,
   input  logic                                 claim_en_i,
   input  logic [SEL_W-1:0]                     claim_sel_i,
   output logic [NUM_REGS-1:0]                  busy_vec_o
);

   logic [DATA_WIDTH-1:0]                 regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]                   busy_q;
   logic [NUM_REGS-1:0]                   busy_d;
   logic [NUM_REGS-1:0]                   w_wr_hit;
   logic [DATA_WIDTH-1:0]                 w_wr_val [NUM_REGS];
   logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  w_rd_data;
   logic [NUM_READ_PORTS-1:0]             w_rd_busy;
   logic [SEL_W-1:0]                      w_sel;

   // Per-register write resolution; later (higher) ports overwrite earlier ones.
   always_comb begin : write_resolve
      for (int r = 0; r < NUM_REGS; r++) begin
         w_wr_hit[r] = 1'b0;
         w_wr_val[r] = '0;
         for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (r != 0 && wr_en_i[j] && wr_sel_i[j*SEL_W +: SEL_W] == SEL_W'(r)) begin
               w_wr_hit[r] = 1'b1;
               w_wr_val[r] = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_comb begin : scoreboard_next
      busy_d = busy_q;
      busy_d[0] = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (claim_en_i && claim_sel_i == SEL_W'(r)) begin
            busy_d[r] = 1'b1;
         end else if (w_wr_hit[r]) begin
            busy_d[r] = 1'b0;
         end
      end
   end

   // r0 never hits, never stores, never goes busy, so it reads 0/not-busy.
   always_comb begin : read_mux
      w_sel     = '0;
      w_rd_data = '0;
      w_rd_busy = '0;
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
         w_sel = rd_sel_i[i*SEL_W +: SEL_W];
         w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_wr_hit[w_sel] ? w_wr_val[w_sel] : regs_q[w_sel];
         w_rd_busy[i] = busy_q[w_sel] && !w_wr_hit[w_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_wr_hit[r]) begin
               regs_q[r] <= w_wr_val[r];
            end
         end
         busy_q <= busy_d;
      end
   end

   generate
      if (REGISTERED_READ != 0) begin : g_reg_read
         logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_q;
         logic [NUM_READ_PORTS-1:0]            rd_busy_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data_q <= '0;
               rd_busy_q <= '0;
            end else begin
               rd_data_q <= w_rd_data;
               rd_busy_q <= w_rd_busy;
            end
         end

         assign rd_data_o = rd_data_q;
         assign rd_busy_o = rd_busy_q;
      end else begin : g_comb_read
         assign rd_data_o = w_rd_data;
         assign rd_busy_o = w_rd_busy;
      end
   endgenerate

   assign busy_vec_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_register_file
// Description : Directed bench: combinational-read default instance driven
//               from a vector table, plus a 32x64, 4-read registered instance.
// Revision    : 1.0
// ============================================================================
module tb_param_register_file;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- instance A: defaults, combinational read ----------------
   logic        a_rst;
   logic [11:0] a_rd_sel;
   logic [95:0] a_rd_data;
   logic [2:0]  a_rd_busy;
   logic [1:0]  a_wr_en;
   logic [7:0]  a_wr_sel;
   logic [63:0] a_wr_data;
   logic        a_claim_en;
   logic [3:0]  a_claim_sel;
   logic [15:0] a_busy_vec;

   param_register_file u_a (
      .clk(clk), .rst(a_rst),
      .rd_sel_i(a_rd_sel), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
      .wr_en_i(a_wr_en), .wr_sel_i(a_wr_sel), .wr_data_i(a_wr_data),
      .claim_en_i(a_claim_en), .claim_sel_i(a_claim_sel), .busy_vec_o(a_busy_vec)
   );

   // ---------------- instance B: 32 x 64, 4 read ports, registered read -----
   logic         b_rst;
   logic [19:0]  b_rd_sel;
   logic [255:0] b_rd_data;
   logic [3:0]   b_rd_busy;
   logic [1:0]   b_wr_en;
   logic [9:0]   b_wr_sel;
   logic [127:0] b_wr_data;
   logic         b_claim_en;
   logic [4:0]   b_claim_sel;
   logic [31:0]  b_busy_vec;

   param_register_file #(
      .DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ_PORTS(4),
      .NUM_WRITE_PORTS(2), .REGISTERED_READ(1)
   ) u_b (
      .clk(clk), .rst(b_rst),
      .rd_sel_i(b_rd_sel), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
      .wr_en_i(b_wr_en), .wr_sel_i(b_wr_sel), .wr_data_i(b_wr_data),
      .claim_en_i(b_claim_en), .claim_sel_i(b_claim_sel), .busy_vec_o(b_busy_vec)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  we;
      logic [3:0]  ws0;
      logic [31:0] wd0;
      logic [3:0]  ws1;
      logic [31:0] wd1;
      logic        ce;
      logic [3:0]  cs;
      logic [3:0]  s0, s1, s2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  busy;
      logic [15:0] bv;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input logic rst, input logic [1:0] we,
      input logic [3:0] ws0, input logic [31:0] wd0,
      input logic [3:0] ws1, input logic [31:0] wd1,
      input logic ce, input logic [3:0] cs,
      input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
      input logic [2:0] busy, input logic [15:0] bv);
      vec_t v;
      v.rst = rst; v.we = we; v.ws0 = ws0; v.wd0 = wd0; v.ws1 = ws1; v.wd1 = wd1;
      v.ce = ce; v.cs = cs; v.s0 = s0; v.s1 = s1; v.s2 = s2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.busy = busy; v.bv = bv;
      tbl.push_back(v);
   endfunction

   task automatic b_step(
      input logic rst, input logic [1:0] we,
      input logic [4:0] ws0, input logic [63:0] wd0,
      input logic [4:0] ws1, input logic [63:0] wd1,
      input logic ce, input logic [4:0] cs, input logic [19:0] sel);
      @(negedge clk);
      b_rst = rst; b_wr_en = we; b_wr_sel = {ws1, ws0}; b_wr_data = {wd1, wd0};
      b_claim_en = ce; b_claim_sel = cs; b_rd_sel = sel;
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] c_BV = 64'hDEADBEEF_01234567;

   initial begin
      a_rst = 1'b1; a_rd_sel = '0; a_wr_en = '0; a_wr_sel = '0; a_wr_data = '0;
      a_claim_en = 1'b0; a_claim_sel = '0;
      b_rst = 1'b1; b_rd_sel = '0; b_wr_en = '0; b_wr_sel = '0; b_wr_data = '0;
      b_claim_en = 1'b0; b_claim_sel = '0;
      @(posedge clk);

      //  rst we ws0 wd0           ws1 wd1           ce cs  s0  s1 s2   d0            d1            d2            busy    bv
      add(1, 0, 0, 0,            0, 0,            0, 0,  0,  5, 15,  0,            0,            0,            3'b000, 16'h0000);
      add(0, 0, 0, 0,            0, 0,            0, 0,  0,  5, 15,  0,            0,            0,            3'b000, 16'h0000);
      add(0, 1, 3, 32'hDEADBEEF, 0, 0,            0, 0,  0,  3,  5,  0,            32'hDEADBEEF, 0,            3'b000, 16'h0000);
      add(0, 0, 0, 0,            0, 0,            0, 0,  3,  3,  0,  32'hDEADBEEF, 32'hDEADBEEF, 0,            3'b000, 16'h0000);
      add(0, 3, 7, 32'h11111111, 7, 32'h22222222, 0, 0,  7,  3,  7,  32'h22222222, 32'hDEADBEEF, 32'h22222222, 3'b000, 16'h0000);
      add(0, 0, 0, 0,            0, 0,            1, 4,  7,  7,  7,  32'h22222222, 32'h22222222, 32'h22222222, 3'b000, 16'h0000);
      add(0, 0, 0, 0,            0, 0,            0, 0,  4,  7,  0,  0,            32'h22222222, 0,            3'b001, 16'h0010);
      add(0, 2, 0, 0,            4, 32'h55,       0, 0,  4,  4,  3,  32'h55,       32'h55,       32'hDEADBEEF, 3'b000, 16'h0010);
      add(0, 1, 9, 32'hAA,       0, 0,            1, 9,  4,  9,  0,  32'h55,       32'hAA,       0,            3'b000, 16'h0000);
      add(0, 3, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0,  9,  0,  9,  32'hAA,       0,            32'hAA,       3'b101, 16'h0200);
      add(0, 1, 2, 32'h1234,     0, 0,            0, 0,  0,  2,  9,  0,            32'h1234,     32'hAA,       3'b100, 16'h0200);
      add(1, 1, 2, 32'h5678,     0, 0,            1, 2,  0,  0,  0,  0,            0,            0,            3'b000, 16'h0200);
      add(0, 0, 0, 0,            0, 0,            0, 0,  2,  9,  3,  0,            0,            0,            3'b000, 16'h0000);
      add(0, 3, 1, 32'h1,        15, 32'hCAFEF00D, 1, 15, 15, 1, 15,  32'hCAFEF00D, 32'h1,        32'hCAFEF00D, 3'b000, 16'h0000);
      add(0, 0, 0, 0,            0, 0,            0, 0,  15, 1, 15,  32'hCAFEF00D, 32'h1,        32'hCAFEF00D, 3'b101, 16'h8000);

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         a_rst = tbl[k].rst; a_wr_en = tbl[k].we;
         a_wr_sel = {tbl[k].ws1, tbl[k].ws0}; a_wr_data = {tbl[k].wd1, tbl[k].wd0};
         a_claim_en = tbl[k].ce; a_claim_sel = tbl[k].cs;
         a_rd_sel = {tbl[k].s2, tbl[k].s1, tbl[k].s0};
         #1;
         chk($sformatf("A%0d rd_data", k), 256'(a_rd_data), 256'({tbl[k].d2, tbl[k].d1, tbl[k].d0}));
         chk($sformatf("A%0d rd_busy", k), 256'(a_rd_busy), 256'(tbl[k].busy));
         chk($sformatf("A%0d busy_vec", k), 256'(a_busy_vec), 256'(tbl[k].bv));
      end

      // Registered-read instance: outputs sampled 1 time unit after each edge.
      b_step(1, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd31, 5'd5, 5'd0});
      chk("B reset rd_data", b_rd_data, 256'd0);
      chk("B reset rd_busy", 256'(b_rd_busy), 256'd0);
      chk("B reset busy_vec", 256'(b_busy_vec), 256'd0);

      @(negedge clk);
      b_rst = 1'b0; b_claim_en = 1'b0; b_claim_sel = '0;
      b_wr_en = 2'b01; b_wr_sel = {5'd0, 5'd3}; b_wr_data = {64'd0, c_BV};
      b_rd_sel = {5'd3, 5'd31, 5'd3, 5'd0};
      #1;
      chk("B latency before edge", 256'(b_rd_data[127:64]), 256'd0);
      @(posedge clk);
      #1;
      chk("B raw bypass", b_rd_data, {c_BV, 64'd0, c_BV, 64'd0});

      b_step(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd3});
      chk("B r3 persists", b_rd_data, {192'd0, c_BV});

      b_step(0, 0, 0, 0, 0, 0, 1, 20, {5'd0, 5'd0, 5'd0, 5'd20});
      chk("B claim rd_busy same cycle", 256'(b_rd_busy), 256'd0);
      chk("B claim busy_vec", 256'(b_busy_vec), 256'h0010_0000);

      b_step(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd20});
      chk("B r20 busy", 256'(b_rd_busy), 256'b0001);

      b_step(0, 2'b10, 0, 0, 20, 64'h55, 0, 0, {5'd0, 5'd0, 5'd0, 5'd20});
      chk("B r20 write data", b_rd_data, 256'h55);
      chk("B r20 write busy", 256'(b_rd_busy), 256'd0);
      chk("B r20 busy_vec clear", 256'(b_busy_vec), 256'd0);

      b_step(0, 2'b01, 2, 64'h1234, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd2});
      chk("B r2 write", b_rd_data, 256'h1234);

      b_step(1, 2'b11, 2, 64'h5678, 2, 64'h9ABC, 1, 2, {5'd0, 5'd0, 5'd3, 5'd2});
      chk("B rst override rd_data", b_rd_data, 256'd0);
      chk("B rst override busy_vec", 256'(b_busy_vec), 256'd0);

      b_step(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd3, 5'd2});
      chk("B after rst rd_data", b_rd_data, 256'd0);
      chk("B after rst busy_vec", 256'(b_busy_vec), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
